mem_arbiter: RTL and testbench

Shares a single slow-memory line port (128-bit line, 28-bit line address) between the instruction cache and the data cache, so the chip needs one external memory instead of separate I and D memories. Sits between the two caches' `mem_*` ports and the external memory port. Serves one full line transaction at a time with round-robin arbitration, and counts completed transactions per requester.

---
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the two cache-side line ports and the shared external memory port.
// The slave modport is the arbiter's view; master is the caches/memory side.
interface mem_arbiter_if;
    logic         i_mem_read;
    logic         i_mem_write;
    logic [27:0]  i_mem_addr;
    logic [127:0] i_mem_wdata;
    logic [127:0] i_mem_rdata;
    logic         i_mem_ready;

    logic         d_mem_read;
    logic         d_mem_write;
    logic [27:0]  d_mem_addr;
    logic [127:0] d_mem_wdata;
    logic [127:0] d_mem_rdata;
    logic         d_mem_ready;

    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport slave (
        input  i_mem_read, i_mem_write, i_mem_addr, i_mem_wdata,
        input  d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
        input  mem_rdata, mem_ready,
        output i_mem_rdata, i_mem_ready, d_mem_rdata, d_mem_ready,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_mem_read, i_mem_write, i_mem_addr, i_mem_wdata,
        output d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
        output mem_rdata, mem_ready,
        input  i_mem_rdata, i_mem_ready, d_mem_rdata, d_mem_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I- and D-cache,
// one full transaction at a time, with per-requester completion counters.
module mem_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             proc_reset,
    mem_arbiter_if.slave     bus,
    output logic [CNT_W-1:0] i_txn_cnt,
    output logic [CNT_W-1:0] d_txn_cnt,
    output logic [1:0]       state_o
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_e;

    // Handshake: a cache raises read/write and holds it until its x_mem_ready
    // strobe; memory sees a held command until it returns a one-cycle mem_ready.
    state_e       state_q, state_d;
    logic         last_d_q, last_d_d;   // 1: the D-cache was served last
    logic         mem_read_q, mem_read_d;
    logic         mem_write_q, mem_write_d;
    logic [27:0]  mem_addr_q, mem_addr_d;
    logic [127:0] mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0] i_cnt_q, i_cnt_d;
    logic [CNT_W-1:0] d_cnt_q, d_cnt_d;

    logic i_req, d_req, grant_i, grant_d;

    assign i_req   = bus.i_mem_read | bus.i_mem_write;
    assign d_req   = bus.d_mem_read | bus.d_mem_write;
    assign grant_i = i_req & (~d_req | last_d_q);
    assign grant_d = d_req & ~grant_i;

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b1;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_cnt_q     <= '0;
            d_cnt_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_cnt_q     <= i_cnt_d;
            d_cnt_q     <= d_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_cnt_d     = i_cnt_q;
        d_cnt_d     = d_cnt_q;
        case (state_q)
            IDLE: begin
                // Write wins when a requester raises both read and write.
                if (grant_i) begin
                    state_d     = SERVE_I;
                    mem_read_d  = bus.i_mem_read & ~bus.i_mem_write;
                    mem_write_d = bus.i_mem_write;
                    mem_addr_d  = bus.i_mem_addr;
                    mem_wdata_d = bus.i_mem_wdata;
                end else if (grant_d) begin
                    state_d     = SERVE_D;
                    mem_read_d  = bus.d_mem_read & ~bus.d_mem_write;
                    mem_write_d = bus.d_mem_write;
                    mem_addr_d  = bus.d_mem_addr;
                    mem_wdata_d = bus.d_mem_wdata;
                end
            end
            SERVE_I: begin
                if (bus.mem_ready) begin
                    state_d     = RELEASE;
                    last_d_d    = 1'b0;
                    i_cnt_d     = i_cnt_q + CNT_W'(1);
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            SERVE_D: begin
                if (bus.mem_ready) begin
                    state_d     = RELEASE;
                    last_d_d    = 1'b1;
                    d_cnt_d     = d_cnt_q + CNT_W'(1);
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion strobe and read data pass straight through for the granted cache only.
    assign bus.i_mem_ready = (state_q == SERVE_I) & bus.mem_ready & ~proc_reset;
    assign bus.d_mem_ready = (state_q == SERVE_D) & bus.mem_ready & ~proc_reset;
    assign bus.i_mem_rdata = ((state_q == SERVE_I) && !proc_reset) ? bus.mem_rdata : '0;
    assign bus.d_mem_rdata = ((state_q == SERVE_D) && !proc_reset) ? bus.mem_rdata : '0;

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign i_txn_cnt     = i_cnt_q;
    assign d_txn_cnt     = d_cnt_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
    localparam int CNT_W = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic clk = 1'b0;
    logic proc_reset;
    always #5 clk = ~clk;

    mem_arbiter_if bus();
    logic [CNT_W-1:0] i_txn_cnt, d_txn_cnt;
    logic [1:0]       state_o;

    mem_arbiter #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .bus        (bus),
        .i_txn_cnt  (i_txn_cnt),
        .d_txn_cnt  (d_txn_cnt),
        .state_o    (state_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: who owns the memory (0 none, 1 I, 2 D), a dead cycle after each
    // completion, who was served last, and the command currently presented.
    int           m_owner, m_last, m_cnt_i, m_cnt_d, lat_left;
    bit           m_dead, i_served, d_served;
    logic         m_rd, m_wr;
    logic [27:0]  m_addr;
    logic [127:0] m_wdata;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic model_update();
        bit ireq, dreq;
        int pick;
        i_served = 0;
        d_served = 0;
        if (proc_reset) begin
            m_owner = 0; m_dead = 0; m_last = 2;
            m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
            m_cnt_i = 0; m_cnt_d = 0;
        end else if (m_owner != 0) begin
            if (bus.mem_ready) begin
                if (m_owner == 1) begin m_cnt_i = (m_cnt_i + 1) % CNT_MOD; i_served = 1; end
                else              begin m_cnt_d = (m_cnt_d + 1) % CNT_MOD; d_served = 1; end
                m_last = m_owner; m_owner = 0; m_dead = 1; m_rd = 0; m_wr = 0;
            end
        end else if (m_dead) begin
            m_dead = 0;
        end else begin
            ireq = bus.i_mem_read | bus.i_mem_write;
            dreq = bus.d_mem_read | bus.d_mem_write;
            pick = 0;
            if (ireq && dreq) pick = (m_last == 1) ? 2 : 1;
            else if (ireq)    pick = 1;
            else if (dreq)    pick = 2;
            if (pick == 1) begin
                m_wr = bus.i_mem_write; m_rd = bus.i_mem_read & ~bus.i_mem_write;
                m_addr = bus.i_mem_addr; m_wdata = bus.i_mem_wdata;
            end else if (pick == 2) begin
                m_wr = bus.d_mem_write; m_rd = bus.d_mem_read & ~bus.d_mem_write;
                m_addr = bus.d_mem_addr; m_wdata = bus.d_mem_wdata;
            end
            if (pick != 0) begin
                m_owner = pick;
                lat_left = $urandom_range(0, 4);
            end
        end
    endtask

    task automatic check_outputs();
        logic [1:0]   exp_state;
        logic [127:0] exp_i_rdata, exp_d_rdata;
        exp_state   = (m_owner == 1) ? 2'd1 : (m_owner == 2) ? 2'd2 : m_dead ? 2'd3 : 2'd0;
        exp_i_rdata = (m_owner == 1 && !proc_reset) ? bus.mem_rdata : '0;
        exp_d_rdata = (m_owner == 2 && !proc_reset) ? bus.mem_rdata : '0;
        chk("mem_read",    128'(bus.mem_read),    128'(m_rd));
        chk("mem_write",   128'(bus.mem_write),   128'(m_wr));
        chk("mem_addr",    128'(bus.mem_addr),    128'(m_addr));
        chk("mem_wdata",   bus.mem_wdata,         m_wdata);
        chk("i_mem_ready", 128'(bus.i_mem_ready), 128'(m_owner == 1 && bus.mem_ready && !proc_reset));
        chk("d_mem_ready", 128'(bus.d_mem_ready), 128'(m_owner == 2 && bus.mem_ready && !proc_reset));
        chk("i_mem_rdata", bus.i_mem_rdata,       exp_i_rdata);
        chk("d_mem_rdata", bus.d_mem_rdata,       exp_d_rdata);
        chk("i_txn_cnt",   128'(i_txn_cnt),       128'(m_cnt_i));
        chk("d_txn_cnt",   128'(d_txn_cnt),       128'(m_cnt_d));
        chk("state",       128'(state_o),         128'(exp_state));
    endtask

    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.i_mem_read = 0; bus.i_mem_write = 0; bus.i_mem_addr = '0; bus.i_mem_wdata = '0;
        bus.d_mem_read = 0; bus.d_mem_write = 0; bus.d_mem_addr = '0; bus.d_mem_wdata = '0;
        bus.mem_ready = 0;  bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        proc_reset = 1;
        tick();
        proc_reset = 0;
    endtask

    int wrap_exp[3] = '{15, 0, 1};

    initial begin
        clear_inputs();
        proc_reset = 1;
        @(posedge clk);
        model_update();
        @(negedge clk);

        // Reset held 2 cycles with both caches requesting; I wins the first tie.
        bus.i_mem_read = 1; bus.i_mem_addr = 28'h1;
        bus.d_mem_read = 1; bus.d_mem_addr = 28'h2;
        tick(); tick();
        chk("rst_mem_read",  128'(bus.mem_read), 128'(0));
        chk("rst_mem_addr",  128'(bus.mem_addr), 128'(0));
        chk("rst_i_cnt",     128'(i_txn_cnt),    128'(0));
        chk("rst_d_cnt",     128'(d_txn_cnt),    128'(0));
        proc_reset = 0;
        tick();
        chk("first_grant_addr", 128'(bus.mem_addr), 128'h1);
        chk("first_grant_read", 128'(bus.mem_read), 128'(1));

        // Single I read, memory answers in the 5th command cycle.
        do_reset();
        bus.i_mem_read = 1; bus.i_mem_addr = 28'h0000010;
        tick();
        chk("single_read", 128'(bus.mem_read), 128'(1));
        chk("single_addr", 128'(bus.mem_addr), 128'h10);
        for (int c = 0; c < 4; c++) tick();
        bus.mem_ready = 1;
        bus.mem_rdata = 128'h0123_4567_89AB_CDEF_0011_2233_DEAD_BEEF;
        #1;
        chk("single_i_ready", 128'(bus.i_mem_ready), 128'(1));
        chk("single_i_rdata", bus.i_mem_rdata, 128'h0123_4567_89AB_CDEF_0011_2233_DEAD_BEEF);
        chk("single_d_ready", 128'(bus.d_mem_ready), 128'(0));
        tick();
        bus.mem_ready = 0; bus.i_mem_read = 0;
        #1;
        chk("single_ready_1cyc", 128'(bus.i_mem_ready), 128'(0));
        chk("single_release",    128'(bus.mem_read),    128'(0));
        tick();
        chk("single_cnt", 128'(i_txn_cnt), 128'(1));

        // Continuous tie: grants alternate, next command 3 cycles after mem_ready.
        do_reset();
        bus.i_mem_read = 1; bus.i_mem_addr = 28'h100;
        bus.d_mem_read = 1; bus.d_mem_addr = 28'h200;
        tick();
        for (int g = 0; g < 4; g++) begin
            chk("tie_cmd",  128'(bus.mem_read), 128'(1));
            chk("tie_addr", 128'(bus.mem_addr), (g % 2 == 0) ? 128'h100 : 128'h200);
            tick(); tick();
            bus.mem_ready = 1;
            tick();
            bus.mem_ready = 0;
            #1 chk("tie_r1", 128'(bus.mem_read), 128'(0));
            tick();
            chk("tie_r2", 128'(bus.mem_read), 128'(0));
            tick();
        end
        chk("tie_i_cnt", 128'(i_txn_cnt), 128'(2));
        chk("tie_d_cnt", 128'(d_txn_cnt), 128'(2));

        // D write-back then refill.
        do_reset();
        bus.d_mem_write = 1; bus.d_mem_addr = 28'h20; bus.d_mem_wdata = {16{8'hA5}};
        tick();
        chk("wb_write", 128'(bus.mem_write), 128'(1));
        chk("wb_read",  128'(bus.mem_read),  128'(0));
        chk("wb_addr",  128'(bus.mem_addr),  128'h20);
        chk("wb_wdata", bus.mem_wdata,       {16{8'hA5}});
        tick();
        bus.mem_ready = 1;
        #1 chk("wb_d_ready", 128'(bus.d_mem_ready), 128'(1));
        tick();
        bus.mem_ready = 0;
        bus.d_mem_write = 0; bus.d_mem_read = 1; bus.d_mem_addr = 28'h30;
        #1;
        chk("wb_rel_write", 128'(bus.mem_write), 128'(0));
        chk("wb_rel_read",  128'(bus.mem_read),  128'(0));
        tick(); tick();
        chk("refill_read", 128'(bus.mem_read), 128'(1));
        chk("refill_addr", 128'(bus.mem_addr), 128'h30);
        bus.mem_ready = 1;
        tick();
        bus.mem_ready = 0; bus.d_mem_read = 0;
        tick(); tick();
        chk("wb_d_cnt", 128'(d_txn_cnt), 128'(2));

        // Reset mid-SERVE_D, then a spurious mem_ready in IDLE.
        do_reset();
        bus.d_mem_read = 1; bus.d_mem_addr = 28'h44;
        tick(); tick();
        chk("mid_serve_d", 128'(state_o), 128'(2));
        proc_reset = 1;
        tick();
        proc_reset = 0; bus.d_mem_read = 0;
        bus.mem_ready = 1;
        #1;
        chk("spur_d_ready", 128'(bus.d_mem_ready), 128'(0));
        chk("spur_i_ready", 128'(bus.i_mem_ready), 128'(0));
        tick();
        bus.mem_ready = 0;
        chk("spur_d_cnt", 128'(d_txn_cnt), 128'(0));
        chk("spur_i_cnt", 128'(i_txn_cnt), 128'(0));
        chk("spur_idle",  128'(state_o),   128'(0));

        // Counter wrap with a 4-bit counter.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            bus.i_mem_read = 1; bus.i_mem_addr = 28'(k);
            tick();
            bus.mem_ready = 1;
            tick();
            bus.mem_ready = 0; bus.i_mem_read = 0;
            tick(); tick();
            if (k >= 14) chk("wrap_cnt", 128'(i_txn_cnt), 128'(wrap_exp[k-14]));
        end

        // Randomized traffic: caches hold requests until served, random latency,
        // spurious mem_ready while nothing is granted, occasional resets.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!(bus.i_mem_read | bus.i_mem_write) || i_served) begin
                int r;
                r = $urandom_range(0, 5);
                bus.i_mem_read  = (r == 0 || r == 1 || r == 3);
                bus.i_mem_write = (r == 2 || r == 3);
                bus.i_mem_addr  = 28'($urandom);
                bus.i_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!(bus.d_mem_read | bus.d_mem_write) || d_served) begin
                int r;
                r = $urandom_range(0, 5);
                bus.d_mem_read  = (r == 0 || r == 1 || r == 3);
                bus.d_mem_write = (r == 2 || r == 3);
                bus.d_mem_addr  = 28'($urandom);
                bus.d_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (m_owner != 0) begin
                if (lat_left == 0) bus.mem_ready = 1;
                else begin bus.mem_ready = 0; lat_left--; end
            end else begin
                bus.mem_ready = ($urandom_range(0, 7) == 0);
            end
            bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            proc_reset = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
